// File: rtl/bf16_mac_lanes_if.sv
// -----------------------------------------------------------------------------
// bf16_mac_lanes_if
// Operand/result bundle between the systolic controller and the BF16 MAC lanes.
//   acc_clear  : abort the current group and zero all accumulation state
//   in_valid   : operand beat present this cycle
//   in_last    : beat closes its group (qualified by in_valid)
//   a_in, b_in : LANES packed BF16 operands, lane i at [16i+15:16i]
//   out_valid  : one-cycle pulse, result vector valid
//   out_data   : LANES packed FP32 group results, lane i at [32i+31:32i]
//   ovf_out    : per-lane overflow flag of the emitted group
// master = controller side, slave = MAC engine side.
// -----------------------------------------------------------------------------
interface bf16_mac_lanes_if #(
   parameter int LANES = 4
);
   logic                  acc_clear;
   logic                  in_valid;
   logic                  in_last;
   logic [LANES*16-1:0]   a_in;
   logic [LANES*16-1:0]   b_in;
   logic                  out_valid;
   logic [LANES*32-1:0]   out_data;
   logic [LANES-1:0]      ovf_out;

   modport master (
      output acc_clear, in_valid, in_last, a_in, b_in,
      input  out_valid, out_data, ovf_out
   );

   modport slave (
      input  acc_clear, in_valid, in_last, a_in, b_in,
      output out_valid, out_data, ovf_out
   );
endinterface

// File: rtl/bf16_mac_lanes.sv
// -----------------------------------------------------------------------------
// bf16_mac_lanes
// Multi-lane BF16 x BF16 multiply with FP32 accumulation per group.
//   Stage 1 : exact BF16 product per lane, registered with valid/last.
//   Stage 2 : FP32 accumulate (truncate or RNE), sticky overflow per lane;
//             a last beat registers the sum onto the outputs and clears the
//             accumulator in the same cycle, so groups run back to back.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : bf16_mac_lanes_if.slave (operands in, results out)
// Parameters:
//   LANES      : number of independent lanes
//   ROUND_MODE : 0 = truncate, 1 = round-to-nearest-even on the accumulate
//   SATURATE   : 1 = clamp overflow to max finite, 0 = emit infinity
// Denormals flush to zero; exponent 0xFF is treated as an ordinary value.
// -----------------------------------------------------------------------------
module bf16_mac_lanes #(
   parameter int LANES      = 4,
   parameter int ROUND_MODE = 0,
   parameter int SATURATE   = 1
) (
   input logic              clk,
   input logic              rst_n,
   bf16_mac_lanes_if.slave  bus
);

   // ---------------------------------------------------------------------------
   // Arithmetic helpers
   // ---------------------------------------------------------------------------

   // Overflow result with the given sign.
   function automatic logic [31:0] ovf_value(input logic sign);
      if (SATURATE != 0) return {sign, 31'h7F7F_FFFF};
      else               return {sign, 8'hFF, 23'd0};
   endfunction

   // Leading-zero count of a 27-bit value (caller guarantees non-zero).
   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] cnt;
      logic       found;
      cnt   = 5'd0;
      found = 1'b0;
      for (int k = 26; k >= 0; k--) begin
         if (!found) begin
            if (v[k]) found = 1'b1;
            else      cnt   = cnt + 5'd1;
         end
      end
      return cnt;
   endfunction

   // Exact BF16 x BF16 product in FP32. Returns {overflow, fp32}.
   function automatic logic [32:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
      logic               sign;
      logic [15:0]        prod;
      logic signed [9:0]  exp_p;
      logic [22:0]        mant;
      sign  = a[15] ^ b[15];
      prod  = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
      // Mantissa product lies in [1,4); a set top bit means [2,4) -> exp+1.
      exp_p = $signed({2'b00, a[14:7]}) + $signed({2'b00, b[14:7]})
              - 10'sd127 + $signed({9'd0, prod[15]});
      mant  = prod[15] ? {prod[14:0], 8'd0} : {prod[13:0], 9'd0};
      if (a[14:7] == 8'd0 || b[14:7] == 8'd0 || exp_p < 10'sd1)
         return 33'd0;
      else if (exp_p > 10'sd254)
         return {1'b1, ovf_value(sign)};
      else
         return {1'b0, sign, exp_p[7:0], mant};
   endfunction

   // FP32 add with guard/round/sticky. Returns {overflow, fp32}.
   function automatic logic [32:0] fp32_add(input logic [31:0] x, input logic [31:0] y);
      logic [31:0]        big;
      logic [31:0]        sml;
      logic [23:0]        m_big;
      logic [23:0]        m_sml;
      logic [7:0]         d;
      logic [26:0]        sml_ext;
      logic [26:0]        sh;
      logic [27:0]        sum;
      logic [26:0]        n;
      logic [4:0]         lz;
      logic signed [9:0]  exp_r;
      logic               inc;
      logic [24:0]        rnd;
      logic [22:0]        mant;

      // Order by magnitude so the subtraction below never goes negative.
      if (x[30:0] >= y[30:0]) begin
         big = x;
         sml = y;
      end else begin
         big = y;
         sml = x;
      end
      m_big = (big[30:23] == 8'd0) ? 24'd0 : {1'b1, big[22:0]};
      m_sml = (sml[30:23] == 8'd0) ? 24'd0 : {1'b1, sml[22:0]};
      d     = big[30:23] - sml[30:23];

      // Three extra low bits: guard, round, sticky. Everything shifted past
      // the sticky position is ORed into it.
      sml_ext = {m_sml, 3'b000};
      if (d >= 8'd27) begin
         sh = {26'd0, |m_sml};
      end else begin
         sh    = sml_ext >> d;
         sh[0] = sh[0] | (|(sml_ext & ~({27{1'b1}} << d)));
      end

      exp_r = $signed({2'b00, big[30:23]});
      if (big[31] == sml[31]) sum = {1'b0, m_big, 3'b000} + {1'b0, sh};
      else                    sum = {1'b0, m_big, 3'b000} - {1'b0, sh};

      if (sum == 28'd0) return 33'd0;  // exact cancellation or 0+0 -> +0

      if (sum[27]) begin
         // Magnitude carry: shift right, keep the lost bit in sticky.
         n     = {sum[27:2], sum[1] | sum[0]};
         exp_r = exp_r + 10'sd1;
      end else begin
         lz    = lzc27(sum[26:0]);
         n     = sum[26:0] << lz;
         exp_r = exp_r - $signed({5'd0, lz});
      end

      inc  = (ROUND_MODE != 0) ? (n[2] & (n[1] | n[0] | n[3])) : 1'b0;
      rnd  = {1'b0, n[26:3]} + {24'd0, inc};
      if (rnd[24]) begin
         // Rounding carried out of the mantissa: value is 2.0 -> 1.0 x 2^(e+1).
         mant  = rnd[23:1];
         exp_r = exp_r + 10'sd1;
      end else begin
         mant  = rnd[22:0];
      end

      if (exp_r < 10'sd1)        return 33'd0;
      else if (exp_r > 10'sd254) return {1'b1, ovf_value(big[31])};
      else                       return {1'b0, big[31], exp_r[7:0], mant};
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic                    p_valid_q,   p_valid_d;
   logic                    p_last_q,    p_last_d;
   logic [LANES-1:0][31:0]  p_data_q,    p_data_d;
   logic [LANES-1:0]        p_ovf_q,     p_ovf_d;

   logic [LANES-1:0][31:0]  acc_q,       acc_d;
   logic [LANES-1:0]        sticky_q,    sticky_d;

   logic                    out_valid_q, out_valid_d;
   logic [LANES-1:0][31:0]  out_data_q,  out_data_d;
   logic [LANES-1:0]        ovf_q,       ovf_d;

   logic [LANES-1:0][32:0]  mul_r;
   logic [LANES-1:0][32:0]  add_r;
   logic [LANES-1:0]        lane_ovf;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path
      // leaves it unassigned, which would infer a latch.
      p_valid_d   = bus.in_valid & ~bus.acc_clear;  // clear drops a same-cycle beat
      p_last_d    = bus.in_last;
      mul_r       = '0;
      add_r       = '0;
      lane_ovf    = '0;
      p_data_d    = '0;
      p_ovf_d     = '0;
      acc_d       = acc_q;
      sticky_d    = sticky_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      ovf_d       = ovf_q;

      for (int i = 0; i < LANES; i++) begin
         mul_r[i]    = bf16_mul(bus.a_in[16*i +: 16], bus.b_in[16*i +: 16]);
         p_data_d[i] = mul_r[i][31:0];
         p_ovf_d[i]  = mul_r[i][32];
         add_r[i]    = fp32_add(acc_q[i], p_data_q[i]);
         lane_ovf[i] = add_r[i][32] | p_ovf_q[i] | sticky_q[i];
      end

      if (bus.acc_clear) begin
         // Abort: no emit, outputs keep their last emitted values.
         acc_d    = '0;
         sticky_d = '0;
      end else if (p_valid_q) begin
         if (p_last_q) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < LANES; i++) begin
               out_data_d[i] = add_r[i][31:0];
            end
            ovf_d    = lane_ovf;
            acc_d    = '0;
            sticky_d = '0;
         end else begin
            for (int i = 0; i < LANES; i++) begin
               acc_d[i] = add_r[i][31:0];
            end
            sticky_d = lane_ovf;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      if (!rst_n) begin
         p_valid_q   <= 1'b0;
         acc_q       <= '0;
         sticky_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         ovf_q       <= '0;
      end else begin
         p_valid_q   <= p_valid_d;
         acc_q       <= acc_d;
         sticky_q    <= sticky_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         ovf_q       <= ovf_d;
      end
   end

   // NOTE: the stage-1 payload is left without reset; it is only consumed
   // when p_valid_q is set, and that bit is reset.
   always_ff @(posedge clk) begin
      p_last_q <= p_last_d;
      p_data_q <= p_data_d;
      p_ovf_q  <= p_ovf_d;
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.ovf_out   = ovf_q;

endmodule
